id_stage_hs: RTL
================

# id_stage_hs

Parametrised instruction-decode stage with a valid/ready handshake on both sides. It sits between the fetch stage and the ID/EX buffer and replaces the single global stall input with per-boundary flow control. A two-entry skid buffer keeps throughput at one instruction per cycle under back-pressure. It adds XLEN generalisation, full RISC-V sign-extended immediates, illegal-instruction flagging and a registered flush.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64. Sets the PC and immediate widths.
- SHAMT_W, $clog2(XLEN): shift-amount width.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  fetch presents an instruction.
- o_ready  out  1  stage can accept; equals !skid_valid (registered).
- i_pc  in  XLEN  PC of the incoming instruction.
- i_instruction  in  32  raw instruction.
- i_flush  in  1  discard all held and incoming instructions.
- o_valid  out  1  decoded instruction held at the output.
- i_ready  in  1  downstream accepts this cycle.
- o_pc  out  XLEN  PC of the output instruction.
- o_rs1_number, o_rs2_number, o_rd_number  out  5 each  register indices; 0 when the field is unused.
- o_immediate  out  XLEN  decoded immediate.
- o_func7  out  7, o_func3  out  3, o_opcode  out  7  decoded fields.
- o_illegal  out  1  instruction not in the supported RV32I/RV64I base subset.

## Operation
- Accept when i_valid && o_ready. Transfer out when o_valid && i_ready.
- Storage:
  - Output register (out_*): drives all outputs.
  - Skid register (skid_*): same payload, plus skid_valid.
- Per-cycle update when not flushing:
  - out empty or transfer out, skid_valid=1: out <= skid, skid_valid <= 0.
  - out empty or transfer out, skid_valid=0, accept: out <= decode(input).
  - out full and no transfer out, accept: skid <= decode(input), skid_valid <= 1.
  - Otherwise hold.
- A decoder stage with o_valid=0 presents all payload outputs as 0.
- Decode is combinational on the input; the result is registered in out or skid. Fields by opcode:
  - ALU (0110011): rs1, rs2, rd, f3, f7.
  - ALUI (0010011): rs1, rd, f3.
    - f3 = 001 or 101: imm = zero-extended instr[20+SHAMT_W-1:20]; f7 = instr[31:25].
    - Else: imm = sext(instr[31:20]).
  - LOAD: rs1, rd, f3, imm = sext(instr[31:20]).
  - STORE: rs1, rs2, f3, imm = sext({instr[31:25], instr[11:7]}).
  - BRANCH: rs1, rs2, f3, imm = sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - JAL: rd, imm = sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - JALR: rs1, rd, f3, imm = sext(instr[31:20]).
  - LUI, AUIPC: rd, imm = sext({instr[31:12], 12'b0}).
  - Unused fields are 0.
- o_illegal = 1 for any of:
  - Unknown opcode; fields are zeroed, opcode is passed through.
  - ALU with f7 not 0000000, or not 0100000 with f3 in {000, 101}.
  - Shift-immediate with an illegal f7 (XLEN=32: must be 0000000 or 0100000, 0100000 only for f3=101).
  - JALR with f3 != 000.
  - BRANCH with f3 in {010, 011}.
- The instruction still flows with o_illegal set; the stage does not trap.
- Flush (registered): o_valid <= 0 and skid_valid <= 0 on the next edge. An accept in the flush cycle is dropped. Flush has priority over every update.

## Timing
- Reset (asserted): o_valid=0, skid_valid=0, o_ready=1, all payload outputs 0; applies immediately, asynchronously.
- Latency: an accepted instruction appears at the output on the next edge (1 cycle) when out is empty or being transferred.
- o_ready is registered; it is never combinationally dependent on i_ready.
- Throughput: 1 per cycle with i_ready held high.
- i_ready low: at most 2 instructions are held. o_ready falls the edge after the skid fills, and rises the edge after the skid drains.
- Order is preserved (FIFO of depth 2).
- Reset mid-operation: all held instructions are lost, and outputs take their reset values without waiting for clk.
- Flush with skid full and i_ready=1: no transfer is issued after the edge; the current cycle's transfer still counts downstream.

## Test plan
- Reset release, then ADDI x1,x0,-1 (0xFFF00093) with i_ready=1 -> next cycle o_valid=1, rd=1, rs1=0, f3=000, imm=0xFFFFFFFF (XLEN=32), o_illegal=0.
- Back-pressure: i_ready=0, three consecutive valid instructions -> first in out, second in skid, o_ready=0 on the third cycle; third not accepted. Raise i_ready -> outputs emerge in order on consecutive cycles.
- BEQ with offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC; rs1 and rs2 decoded; rd=0.
- XLEN=64: SRAI x2,x2,33 (0x42115113) -> imm=33, f7=0100000, illegal=0. The same word at XLEN=32 -> illegal=1.
- Flush with both entries full -> o_valid=0 and o_ready=1 after one edge; a concurrent i_valid instruction never appears.
- Opcode 0x7F, and ALU with f7=0000001 -> o_illegal=1, o_valid=1, rs/rd fields 0 for the unknown opcode.

Source files
------------

// File: rtl/id_stage_hs.sv
// rtl/id_stage_hs.sv - RISC-V decode stage with valid/ready handshake and a two-entry skid buffer
module id_stage_hs #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instruction,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1_number,
  output logic [4:0]      o_rs2_number,
  output logic [4:0]      o_rd_number,
  output logic [XLEN-1:0] o_immediate,
  output logic [6:0]      o_func7,
  output logic [2:0]      o_func3,
  output logic [6:0]      o_opcode,
  output logic            o_illegal
);

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  // On RV64 the shift amount borrows instr[25]; mask it out of the shift funct7.
  localparam logic [6:0] F7_SH_MASK = 7'(~((32'd1 << (SHAMT_W - 5)) - 32'd1));

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [6:0]      op;
    logic            ill;
  } dec_t;

  dec_t dec;
  dec_t out_q;
  dec_t skid_q;
  dec_t shown;
  logic out_valid;
  logic skid_valid;
  logic accept;
  logic xfer;

  logic [6:0]         f7_raw;
  logic [6:0]         f7_sh;
  logic [2:0]         f3_raw;
  logic signed [11:0] imm12_i;
  logic signed [11:0] imm12_s;
  logic signed [12:0] imm13_b;
  logic signed [20:0] imm21_j;
  logic signed [31:0] imm32_u;
  logic [XLEN-1:0]    imm_sh;

  assign f7_raw  = i_instruction[31:25];
  assign f7_sh   = f7_raw & F7_SH_MASK;
  assign f3_raw  = i_instruction[14:12];
  assign imm12_i = i_instruction[31:20];
  assign imm12_s = {i_instruction[31:25], i_instruction[11:7]};
  assign imm13_b = {i_instruction[31], i_instruction[7], i_instruction[30:25],
                    i_instruction[11:8], 1'b0};
  assign imm21_j = {i_instruction[31], i_instruction[19:12], i_instruction[20],
                    i_instruction[30:21], 1'b0};
  assign imm32_u = {i_instruction[31:12], 12'b0};
  assign imm_sh  = XLEN'(i_instruction[20 +: SHAMT_W]);

  always_comb begin
    dec     = '0;
    dec.pc  = i_pc;
    dec.op  = i_instruction[6:0];
    case (i_instruction[6:0])
      OP_ALU: begin
        dec.rs1 = i_instruction[19:15];
        dec.rs2 = i_instruction[24:20];
        dec.rd  = i_instruction[11:7];
        dec.f3  = f3_raw;
        dec.f7  = f7_raw;
        dec.ill = !((f7_raw == 7'b0) ||
                    (f7_raw == F7_ALT && (f3_raw == 3'b000 || f3_raw == 3'b101)));
      end
      OP_ALUI: begin
        dec.rs1 = i_instruction[19:15];
        dec.rd  = i_instruction[11:7];
        dec.f3  = f3_raw;
        if (f3_raw == 3'b001 || f3_raw == 3'b101) begin
          dec.imm = imm_sh;
          dec.f7  = f7_sh;
          dec.ill = !((f7_sh == 7'b0) || (f7_sh == F7_ALT && f3_raw == 3'b101));
        end else begin
          dec.imm = XLEN'(imm12_i);
        end
      end
      OP_LOAD: begin
        dec.rs1 = i_instruction[19:15];
        dec.rd  = i_instruction[11:7];
        dec.f3  = f3_raw;
        dec.imm = XLEN'(imm12_i);
      end
      OP_STORE: begin
        dec.rs1 = i_instruction[19:15];
        dec.rs2 = i_instruction[24:20];
        dec.f3  = f3_raw;
        dec.imm = XLEN'(imm12_s);
      end
      OP_BRANCH: begin
        dec.rs1 = i_instruction[19:15];
        dec.rs2 = i_instruction[24:20];
        dec.f3  = f3_raw;
        dec.imm = XLEN'(imm13_b);
        dec.ill = (f3_raw == 3'b010) || (f3_raw == 3'b011);
      end
      OP_JAL: begin
        dec.rd  = i_instruction[11:7];
        dec.imm = XLEN'(imm21_j);
      end
      OP_JALR: begin
        dec.rs1 = i_instruction[19:15];
        dec.rd  = i_instruction[11:7];
        dec.f3  = f3_raw;
        dec.imm = XLEN'(imm12_i);
        dec.ill = (f3_raw != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = i_instruction[11:7];
        dec.imm = XLEN'(imm32_u);
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign accept = i_valid && o_ready;
  assign xfer   = out_valid && i_ready;

  // Skid only fills while out is stalled, so skid_valid implies out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || xfer) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign shown        = out_valid ? out_q : '0;
  assign o_ready      = !skid_valid;
  assign o_valid      = out_valid;
  assign o_pc         = shown.pc;
  assign o_rs1_number = shown.rs1;
  assign o_rs2_number = shown.rs2;
  assign o_rd_number  = shown.rd;
  assign o_immediate  = shown.imm;
  assign o_func7      = shown.f7;
  assign o_func3      = shown.f3;
  assign o_opcode     = shown.op;
  assign o_illegal    = shown.ill;

endmodule
